// File: rtl/atsc_rx_pkg.sv
// Shared constants for the ATSC RX derandomizer: sync byte, PRBS LFSR
// definition and packet geometry.
package atsc_rx_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE      = 8'h47;
    localparam logic [15:0] LFSR_SEED         = 16'hF180;
    // x^16+x^13+x^12+x^11+x^7+x^6+x^3+x+1, bit e-1 set for each term x^e
    localparam logic [15:0] LFSR_POLY         = 16'h9C65;
    // Element [7] feeds D7 (byte MSB), element [0] feeds D0
    localparam logic [7:0][3:0] DERAND_TAPS   = {4'd15, 4'd13, 4'd12, 4'd10,
                                                 4'd9,  4'd8,  4'd6,  4'd5};
    localparam int          PKT_PAYLOAD_BYTES = 187;
    localparam int          PKT_WORDS         = 47;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } sync_state_t;

    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LFSR_POLY);
    endfunction

endpackage

// File: rtl/atsc_prbs_step.sv
// One byte-step of the Fibonacci PRBS LFSR: PRBS byte taken from the
// current state, then a single shift.
module atsc_prbs_step
    import atsc_rx_pkg::*;
(
    input  logic [15:0] state,
    output logic [15:0] next_state,
    output logic [7:0]  prbs
);

    // Tap selection before the shift, then shift left with XOR feedback
    always_comb begin
        prbs = 8'h00;
        for (int j = 0; j < 8; j++) begin
            prbs[j] = state[DERAND_TAPS[j]];
        end
        next_state = {state[14:0], lfsr_feedback(state)};
    end

endmodule

// File: rtl/atsc_derandomizer.sv
// Removes the ATSC energy-dispersal PRBS from 187-byte RS payloads and
// emits 188-byte MPEG-TS packets with the 0x47 sync byte prepended.
module atsc_derandomizer #(
    parameter logic [15:0] SEED      = 16'hF180,
    parameter int          PKT_WORDS = 47
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] in_tdata,
    input  logic        in_tuser,
    input  logic        in_tlast,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [31:0] out_tdata,
    output logic        out_tlast,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic        synced,
    output logic        len_err,
    input  logic        clear_err
);
    import atsc_rx_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(PKT_WORDS - 1);

    sync_state_t      state;
    logic [5:0]       cnt;
    logic [15:0]      lfsr;
    logic [7:0]       carry;
    logic [4:0][15:0] chain;
    logic [3:0][7:0]  prbs;
    logic [3:0][7:0]  din;
    logic [3:0][7:0]  dd;
    logic             accept, first, reseed, active, at_last, err;
    logic [31:0]      word;
    logic [15:0]      lfsr_next;

    assign in_tready = !out_tvalid || out_tready;
    assign din       = in_tdata;
    assign chain[0]  = reseed ? SEED : lfsr;

    for (genvar g = 0; g < 4; g++) begin : g_step
        atsc_prbs_step u_step (
            .state      (chain[g]),
            .next_state (chain[g+1]),
            .prbs       (prbs[g])
        );
    end

    // Per-word decode: framing position, descrambled bytes, output word
    always_comb begin
        accept  = in_tvalid && in_tready;
        first   = (cnt == 6'd0);
        reseed  = first && in_tuser;
        active  = (state == SYNC) || reseed;
        at_last = (cnt == LAST_IDX);
        err     = accept && active && (in_tlast != at_last);
        dd      = din;
        for (int j = 0; j < 4; j++) begin
            // din[3] holds the earliest byte, which pairs with prbs[0]
            dd[3-j] = din[3-j] ^ (enable ? prbs[j] : 8'h00);
        end
        word      = {(first ? TS_SYNC_BYTE : carry), dd[3], dd[2], dd[1]};
        // Pad byte of the final word must not advance the sequence
        lfsr_next = at_last ? chain[3] : chain[4];
    end

    // Sync FSM, framing counter, LFSR, carry byte and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= UNSYNC;
            cnt        <= 6'd0;
            lfsr       <= SEED;
            carry      <= 8'h00;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            out_tdata  <= 32'h0000_0000;
            synced     <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            if (accept) begin
                lfsr       <= lfsr_next;
                carry      <= dd[0];
                cnt        <= (in_tlast || at_last) ? 6'd0 : cnt + 6'd1;
                out_tvalid <= active;
                if (reseed) begin
                    state  <= SYNC;
                    synced <= 1'b1;
                end else begin
                    state  <= state;
                    synced <= synced;
                end
                if (active) begin
                    out_tdata <= word;
                    out_tlast <= in_tlast || at_last;
                end else begin
                    out_tdata <= out_tdata;
                    out_tlast <= out_tlast;
                end
            end else if (out_tready) begin
                out_tvalid <= 1'b0;
            end else begin
                out_tvalid <= out_tvalid;
            end
            if (err) begin
                len_err <= 1'b1;
            end else if (clear_err) begin
                len_err <= 1'b0;
            end else begin
                len_err <= len_err;
            end
        end
    end

endmodule

// File: tb/tb_atsc_derandomizer.sv
// Scoreboard bench for atsc_derandomizer: directed packets, expected words
// queued at issue time and checked by an independent output monitor.
module tb_atsc_derandomizer;

    logic        clk = 1'b0;
    logic        reset = 1'b1, enable = 1'b0, in_tuser = 1'b0, in_tlast = 1'b0;
    logic        in_tvalid = 1'b0, in_tready, out_tlast, out_tvalid;
    logic        out_tready = 1'b1, synced, len_err, clear_err = 1'b0;
    logic [31:0] in_tdata = 32'h0, out_tdata;

    int          total = 0;
    int          bad = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  prbs [0:767];
    bit          rand_rdy = 1'b0;
    bit          rand_gap = 1'b0;
    logic        held_v = 1'b0;
    logic        held_l;
    logic [31:0] held_d;

    atsc_derandomizer dut (
        .clk(clk), .reset(reset), .enable(enable), .in_tdata(in_tdata),
        .in_tuser(in_tuser), .in_tlast(in_tlast), .in_tvalid(in_tvalid),
        .in_tready(in_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .synced(synced),
        .len_err(len_err), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each transfer, checks stall hold
    always @(negedge clk) begin
        logic [32:0] e;
        if (!reset) begin
            if (held_v) begin
                check("stall_valid", {31'd0, out_tvalid}, 32'd1);
                check("stall_data", out_tdata, held_d);
                check("stall_last", {31'd0, out_tlast}, {31'd0, held_l});
            end
            if (out_tvalid && out_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_tdata, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_tdata, e[31:0]);
                    check("out_last", {31'd0, out_tlast}, {31'd0, e[32]});
                end
            end
            held_v = out_tvalid && !out_tready;
            held_d = out_tdata;
            held_l = out_tlast;
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_tready = rand_rdy ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    task automatic send_word(input logic [31:0] data, input logic user, input logic last);
        int n;
        int g;
        g = rand_gap ? $urandom_range(0, 2) : 0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_tdata  = data;
        in_tuser  = user;
        in_tlast  = last;
        in_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_tready && n < 500);
        if (!in_tready) begin
            $display("FAIL in_tready_timeout: got 0 want 1");
            $fatal(1, "input handshake stuck");
        end
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tuser  = 1'b0;
        in_tlast  = 1'b0;
    endtask

    // mode 0: b(i)=i+1, mode 1: zeros, mode 2: i*7+3; off indexes the golden PRBS
    task automatic send_packet(input int mode, input bit flag, input int off, input bit en,
                               input bit expect_out, input int nwords, input bit send_last);
        logic [7:0] b [0:187];
        logic [7:0] ob [0:187];
        logic       lst;
        for (int i = 0; i < 188; i++) begin
            b[i] = (mode == 0) ? 8'(i + 1) : (mode == 1) ? 8'h00 : 8'(i * 7 + 3);
        end
        b[187] = 8'hA5;
        ob[0] = 8'h47;
        for (int i = 0; i < 187; i++) begin
            ob[i+1] = b[i] ^ (en ? prbs[off+i] : 8'h00);
        end
        enable = en;
        for (int k = 0; k < nwords; k++) begin
            lst = send_last && (k == nwords - 1);
            if (expect_out) begin
                exp_q.push_back({lst || (k == 46), ob[4*k], ob[4*k+1], ob[4*k+2], ob[4*k+3]});
            end
            send_word({b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]},
                      (k == 0) ? flag : (k == 5), lst);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [15:0] s;
        s = 16'hF180;
        for (int i = 0; i < 768; i++) begin
            prbs[i] = {s[15], s[13], s[12], s[10], s[9], s[8], s[6], s[5]};
            s = {s[14:0], s[15] ^ s[12] ^ s[11] ^ s[10] ^ s[6] ^ s[5] ^ s[2] ^ s[0]};
        end

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_tvalid", {31'd0, out_tvalid}, 32'd0);
        check("rst_tlast", {31'd0, out_tlast}, 32'd0);
        check("rst_tdata", out_tdata, 32'd0);
        check("rst_synced", {31'd0, synced}, 32'd0);
        check("rst_len_err", {31'd0, len_err}, 32'd0);

        // Unflagged packets before any field start are swallowed
        send_packet(2, 1'b0, 0, 1'b1, 1'b0, 47, 1'b1);
        send_packet(2, 1'b0, 0, 1'b1, 1'b0, 47, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("presync_synced", {31'd0, synced}, 32'd0);

        // Bypass: pure realignment plus sync insert
        send_packet(0, 1'b1, 0, 1'b0, 1'b1, 47, 1'b1);
        wait_drain();
        check("bypass_synced", {31'd0, synced}, 32'd1);

        // Descramble zeros: seed run, continuation, reseed
        send_packet(1, 1'b1, 0,   1'b1, 1'b1, 47, 1'b1);
        send_packet(1, 1'b0, 187, 1'b1, 1'b1, 47, 1'b1);
        send_packet(1, 1'b1, 0,   1'b1, 1'b1, 47, 1'b1);
        wait_drain();

        // Backpressure and input gaps
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        send_packet(2, 1'b1, 0,   1'b1, 1'b1, 47, 1'b1);
        send_packet(2, 1'b0, 187, 1'b1, 1'b1, 47, 1'b1);
        send_packet(0, 1'b0, 374, 1'b1, 1'b1, 47, 1'b1);
        wait_drain();
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_err_len_err", {31'd0, len_err}, 32'd0);

        // Short packet: tlast on word 20, then the next packet restarts at word 0
        send_packet(2, 1'b1, 0, 1'b1, 1'b1, 21, 1'b1);
        check("short_len_err", {31'd0, len_err}, 32'd1);
        send_packet(1, 1'b0, 84, 1'b1, 1'b1, 47, 1'b1);
        wait_drain();
        check("sticky_len_err", {31'd0, len_err}, 32'd1);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        check("clear_len_err", {31'd0, len_err}, 32'd0);

        // Reset at word 10 of a packet
        send_packet(0, 1'b1, 0, 1'b1, 1'b1, 10, 1'b0);
        reset     = 1'b1;
        in_tdata  = 32'h2A2B2C2D;
        in_tvalid = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_tvalid", {31'd0, out_tvalid}, 32'd0);
        check("mid_rst_tlast", {31'd0, out_tlast}, 32'd0);
        check("mid_rst_tdata", out_tdata, 32'd0);
        check("mid_rst_synced", {31'd0, synced}, 32'd0);
        in_tvalid = 1'b0;
        reset     = 1'b0;
        exp_q.delete();
        send_packet(0, 1'b1, 0, 1'b1, 1'b1, 47, 1'b1);
        wait_drain();
        check("final_synced", {31'd0, synced}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/atsc_derandomizer.md
Name: atsc_derandomizer

Overview:
- Stage directly downstream of the ATSC RS decoder core, sitting between that core's output stream and the AXI wrapper input stream in the ATSC RX RFNoC chain.
- Takes 187-byte RS-corrected segment payloads and removes the ATSC energy-dispersal PRBS by XORing with a 16-bit LFSR sequence.
- Inserts the MPEG-TS sync byte 0x47 and emits 188-byte transport packets.
- The LFSR is reseeded at each field start, flagged on the input stream.

Parameters:
- SEED, 16'hF180, LFSR value loaded at field start.
- PKT_WORDS, 47, 32-bit words per packet on both input and output.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = XOR with PRBS; 0 = bypass XOR (realignment and sync insert still done).
- in_tdata  in  32  four payload bytes; byte order is earliest byte in [31:24].
- in_tuser  in  1  field-start flag; sampled on the first word of a packet only.
- in_tlast  in  1  last word of input packet.
- in_tvalid  in  1  AXIS valid.
- in_tready  out  1  AXIS ready.
- out_tdata  out  32  transport-packet bytes; earliest byte in [31:24].
- out_tlast  out  1  last word of 188-byte packet.
- out_tvalid  out  1  AXIS valid.
- out_tready  in  1  AXIS ready.
- synced  out  1  1 once a field start has been seen.
- len_err  out  1  sticky; set on a packet-length mismatch.
- clear_err  in  1  single-cycle pulse; clears len_err.

Behaviour:
- Input framing: word k carries b(4k)..b(4k+3), k = 0..46. Word 46 carries b184, b185, b186 and a pad byte in [7:0], which is ignored.
- Output mapping is one output word per accepted input word:
  - out word 0 = {0x47, d0, d1, d2}.
  - out word k (k ≥ 1) = {d(4k-1), d(4k), d(4k+1), d(4k+2)}.
  - d(4k-1) comes from an 8-bit carry register holding byte 3 of the previous input word.
- Descrambling: d(i) = b(i) XOR P(i) when enable = 1; d(i) = b(i) when enable = 0.
  - The LFSR shifts once per payload byte: 4 shifts per word, 3 shifts for word 46 (the pad byte does not advance it).
  - The 4 steps are unrolled combinationally.
  - The LFSR advances whether or not enable is set.
- LFSR: Fibonacci form, polynomial x^16+x^13+x^12+x^11+x^7+x^6+x^3+x+1.
  - P(i) = 8 stages selected by the package tap table, sampled before each shift.
  - On a first word with in_tuser = 1, the LFSR loads SEED and that word uses P from the SEED state.
- Output register and handshake:
  - Single registered output stage; in_tready = !out_tvalid || out_tready.
  - Latency is 1 cycle from input accept to out_tvalid.
  - Full throughput with a continuous ready; no combinational path from in_tvalid to out_tvalid.
  - out_tdata and out_tlast hold stable while out_tvalid && !out_tready.
- State machine, states UNSYNC and SYNC:
  - UNSYNC: input words are accepted and discarded; out_tvalid stays 0.
  - UNSYNC → SYNC on accepting a first word with in_tuser = 1. That packet is output.
  - SYNC: packets are processed. A later field-start flag reseeds the LFSR and stays in SYNC.
  - in_tuser on any word other than the first is ignored.
- Word counter (6 bits) counts accepted words and returns to 0 on an accepted in_tlast.
- Length check:
  - in_tlast with counter ≠ 46: set len_err, output out_tlast with that word, restart at word 0. The carry register is not used across packets.
  - counter = 46 without in_tlast: set len_err, force out_tlast on that word, and treat the next word as a first word.
  - clear_err and a new error in the same cycle: the error wins.
- Reset values: out_tvalid 0, out_tlast 0, out_tdata 0, synced 0, len_err 0, state UNSYNC, counter 0, LFSR SEED, carry 0.
- Reset mid-packet drops the partial output; the block returns to UNSYNC.

Decomposition:
- Package atsc_rx_pkg holds:
  - TS_SYNC_BYTE = 8'h47.
  - LFSR_SEED.
  - LFSR_POLY mask.
  - DERAND_TAPS: 8 stage indices for output bits D7..D0, per A/53 Annex D.
  - PKT_PAYLOAD_BYTES = 187.
  - PKT_WORDS = 47.
- One sub-module, atsc_prbs_step: purely combinational. Maps the 16-bit state to the next state and an 8-bit PRBS byte; instantiated 4 times in a chain.

Test Plan:
- enable = 0, field-start packet of words 0x01020304, 0x05060708, … → out word 0 = 0x47010203, word 1 = 0x04050607; out_tlast on word 46; synced = 1.
- enable = 1, all-zero payload after field start → 188 output bytes equal 0x47 followed by the first 187 golden-model PRBS bytes from SEED. A second packet without the flag continues the sequence; a third packet with the flag restarts it at the SEED state.
- Packets sent before any field start → no output. The first flagged packet is output in full.
- Random out_tready at 30% duty and random in_tvalid gaps across 3 packets → byte stream identical to the no-stall run; out_tdata stable during stalls.
- Input in_tlast on word 20 → len_err = 1, out_tlast on output word 20, next packet processed from word 0. A clear_err pulse then returns len_err to 0.
- reset asserted at word 10 of a packet → all outputs at reset values next cycle. After release, a flagged packet produces correct output.
